pcr_access_arbiter: RTL and testbench
=====================================

// Module: pcr_access_arbiter
// PURPOSE
//  Shares the single-port PCR (processor control register) file between the core and the host.
//  Both requesters use a valid/ready request channel. The block grants one requester and
//    sequences exactly one PCR access at a time, then returns the response to that requester.
//  Sits between the core pipeline / host interface and the PCR file (status_im and peers).
// PARAMETERS
//  ADDR_W        5    PCR address width
//  DATA_W        64   PCR data width
//  STARVE_LIMIT  8    host wait cycles before forced host grant (PCR_ARB_STARVE_EN only)
// PORTS
//  clk                 in   1       clock; all state changes on posedge
//  reset_n             in   1       asynchronous, active-low reset
//  io_core_req_valid   in   1       core request present
//  io_core_req_ready   out  1       core request accepted this cycle
//  io_core_req_rw      in   1       1=write, 0=read
//  io_core_req_addr    in   ADDR_W  PCR index
//  io_core_req_data    in   DATA_W  write data
//  io_core_resp_valid  out  1       one-cycle response pulse to core
//  io_core_resp_data   out  DATA_W  read data (0 for writes)
//  io_host_req_valid / _ready / _rw / _addr / _data   same meaning as core, host side
//  io_host_resp_valid  out  1       host response, held until accepted
//  io_host_resp_ready  in   1       host accepts response
//  io_host_resp_data   out  DATA_W  read data (0 for writes)
//  io_pcr_en           out  1       PCR access strobe, exactly one cycle per access
//  io_pcr_wen          out  1       write qualifier, valid with io_pcr_en
//  io_pcr_addr         out  ADDR_W  PCR index, valid with io_pcr_en
//  io_pcr_wdata        out  DATA_W  PCR write data, valid with io_pcr_en
//  io_pcr_rdata        in   DATA_W  PCR read data, valid the cycle after io_pcr_en
//  io_busy             out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; owner, rw, addr, data and resp_data registers are 0.
//    All outputs are 0 during and after reset, so no io_pcr_en is issued out of reset.
//  FSM states: IDLE -> ISSUE -> CAPT -> RESP -> IDLE.
//  IDLE
//    - Grant: core wins when both valids are high. The winner's req_ready is high combinationally;
//      the loser's req_ready is 0. No grant and no ready outside IDLE.
//    - On fire (valid & ready), latch owner, rw, addr and data, then go to ISSUE.
//  ISSUE
//    - Drive io_pcr_en=1 and io_pcr_wen=rw for exactly one cycle, with the latched addr and
//      data on io_pcr_addr / io_pcr_wdata, then go to CAPT.
//  CAPT
//    - Register io_pcr_rdata into resp_data if rw=0; load 0 if rw=1. Go to RESP.
//  RESP
//    - Owner core: io_core_resp_valid=1 for one cycle, then IDLE.
//    - Owner host: io_host_resp_valid stays high with stable data until io_host_resp_ready=1,
//      then IDLE in the same cycle.
//  Latency: request fire in cycle N -> pcr_en in N+1 -> resp_valid in N+3. Throughput is one
//    access per 4 cycles; the next grant is possible in the cycle after RESP exits.
//  Single outstanding access: a host response stalled by host_resp_ready=0 blocks core requests.
//  Response data for an owner is only driven while its resp_valid is high; otherwise 0.
//  Requests that are valid but not granted are not consumed; requesters hold fields stable.
//  Async reset mid-access: the in-flight access is dropped with no response.
//    If reset lands after ISSUE, the PCR write may already be done; that is permitted.
// CONFIGURATION
//  PCR_ARB_STARVE_EN defined:
//    - A saturating host wait counter increments each IDLE cycle in which the host is valid
//      but not granted. It clears on a host grant.
//    - When the counter >= STARVE_LIMIT, the host wins the next IDLE arbitration over the core.
//  PCR_ARB_STARVE_EN undefined: pure fixed priority with core first; no counter is built.
// TESTING
//  T1 - Core read, addr=5'h03, PCR returns 64'hAB:
//       pcr_en=1 (wen=0, addr=3) at N+1; core_resp_valid=1 with data 64'hAB at N+3 only.
//  T2 - Host write, addr=5'h1F, data=64'hDEAD_BEEF, resp_ready held 0 for 5 cycles:
//       pcr_wen=1 with that data at N+1; host_resp_valid stays high with data 0 until ready.
//  T3 - Core and host valid in the same IDLE cycle: core granted (host_req_ready=0);
//       host is granted in the first IDLE cycle after the core response.
//  T4 - Host response stalled while a core request is pending: core_req_ready stays 0;
//       the core is granted the cycle after host_resp_ready rises.
//  T5 - reset_n asserted in CAPT: all outputs drop to 0 asynchronously.
//       After release, no resp_valid and no pcr_en occur without a new request.
//  T6 (PCR_ARB_STARVE_EN, STARVE_LIMIT=8) - core valid continuously, host valid:
//       host is granted after at most 8 IDLE losses. Without the macro, the host is never granted.

Source files
------------

// File: rtl/pcr_access_arbiter.sv
// Arbitrates core and host requests onto the single-port PCR file, one access at a time.
// Optional host anti-starvation counter is built when PCR_ARB_STARVE_EN is defined.
module pcr_access_arbiter #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              io_core_req_valid,
  output logic              io_core_req_ready,
  input  logic              io_core_req_rw,
  input  logic [ADDR_W-1:0] io_core_req_addr,
  input  logic [DATA_W-1:0] io_core_req_data,
  output logic              io_core_resp_valid,
  output logic [DATA_W-1:0] io_core_resp_data,
  input  logic              io_host_req_valid,
  output logic              io_host_req_ready,
  input  logic              io_host_req_rw,
  input  logic [ADDR_W-1:0] io_host_req_addr,
  input  logic [DATA_W-1:0] io_host_req_data,
  output logic              io_host_resp_valid,
  input  logic              io_host_resp_ready,
  output logic [DATA_W-1:0] io_host_resp_data,
  output logic              io_pcr_en,
  output logic              io_pcr_wen,
  output logic [ADDR_W-1:0] io_pcr_addr,
  output logic [DATA_W-1:0] io_pcr_wdata,
  input  logic [DATA_W-1:0] io_pcr_rdata,
  output logic              io_busy,
  output logic [1:0]        dbg_state
);

  // Request channels: a transfer happens in a cycle where valid and ready are both high.
  // Ready is only ever raised in IDLE for the arbitration winner; requesters keep valid and
  // fields stable until that cycle. The host response holds until resp_ready is seen high.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = host owns the access
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              core_grant;
  logic              host_grant;
  logic              host_first;

`ifdef PCR_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign host_first = (wait_cnt_q >= CNT_W'(STARVE_LIMIT));

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (host_grant) begin
      wait_cnt_d = '0;
    end else if (state_q == ST_IDLE && io_host_req_valid &&
                 wait_cnt_q < CNT_W'(STARVE_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign host_first = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_data_d = resp_data_q;
    core_grant  = 1'b0;
    host_grant  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (io_core_req_valid && !(io_host_req_valid && host_first)) begin
          core_grant = 1'b1;
        end else if (io_host_req_valid) begin
          host_grant = 1'b1;
        end
        if (core_grant) begin
          owner_d = 1'b0;
          rw_d    = io_core_req_rw;
          addr_d  = io_core_req_addr;
          data_d  = io_core_req_data;
          state_d = ST_ISSUE;
        end else if (host_grant) begin
          owner_d = 1'b1;
          rw_d    = io_host_req_rw;
          addr_d  = io_host_req_addr;
          data_d  = io_host_req_data;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_CAPT;
      ST_CAPT: begin
        resp_data_d = rw_q ? '0 : io_pcr_rdata;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (!owner_q || io_host_resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      owner_q     <= 1'b0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Readies are masked by reset so nothing looks accepted while reset is held.
  assign io_core_req_ready  = core_grant & reset_n;
  assign io_host_req_ready  = host_grant & reset_n;

  assign io_pcr_en          = (state_q == ST_ISSUE);
  assign io_pcr_wen         = io_pcr_en & rw_q;
  assign io_pcr_addr        = io_pcr_en ? addr_q : '0;
  assign io_pcr_wdata       = io_pcr_en ? data_q : '0;

  assign io_core_resp_valid = (state_q == ST_RESP) & ~owner_q;
  assign io_host_resp_valid = (state_q == ST_RESP) & owner_q;
  assign io_core_resp_data  = io_core_resp_valid ? resp_data_q : '0;
  assign io_host_resp_data  = io_host_resp_valid ? resp_data_q : '0;

  assign io_busy            = (state_q != ST_IDLE);
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_pcr_access_arbiter.sv
// Bench for pcr_access_arbiter: models the PCR file, predicts responses from a memory model,
// and checks latency, arbitration order, host stall, mid-access reset and host starvation.
module tb_pcr_access_arbiter;
  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 64;
  localparam int STARVE_LIMIT = 8;

  typedef struct {
    int          cyc;
    logic        wen;
    logic [4:0]  addr;
    logic [63:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        core_req_valid, core_req_ready, core_req_rw;
  logic [4:0]  core_req_addr;
  logic [63:0] core_req_data;
  logic        core_resp_valid;
  logic [63:0] core_resp_data;
  logic        host_req_valid, host_req_ready, host_req_rw;
  logic [4:0]  host_req_addr;
  logic [63:0] host_req_data;
  logic        host_resp_valid, host_resp_ready;
  logic [63:0] host_resp_data;
  logic        pcr_en, pcr_wen;
  logic [4:0]  pcr_addr;
  logic [63:0] pcr_wdata, pcr_rdata;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] pcr_mem[32];
  logic [63:0] ref_mem[32];
  logic [63:0] core_exp_q[$];
  logic [63:0] host_exp_q[$];
  acc_t        en_log[$];
  acc_t        exp_acc_q[$];
  bit          rd_hold = 1'b0;

  logic [205:0] outs;
  assign outs = {core_req_ready, core_resp_valid, core_resp_data, host_req_ready,
                 host_resp_valid, host_resp_data, pcr_en, pcr_wen, pcr_addr, pcr_wdata,
                 busy, dbg_state};

  pcr_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .io_core_req_valid(core_req_valid), .io_core_req_ready(core_req_ready),
    .io_core_req_rw(core_req_rw), .io_core_req_addr(core_req_addr),
    .io_core_req_data(core_req_data),
    .io_core_resp_valid(core_resp_valid), .io_core_resp_data(core_resp_data),
    .io_host_req_valid(host_req_valid), .io_host_req_ready(host_req_ready),
    .io_host_req_rw(host_req_rw), .io_host_req_addr(host_req_addr),
    .io_host_req_data(host_req_data),
    .io_host_resp_valid(host_resp_valid), .io_host_resp_ready(host_resp_ready),
    .io_host_resp_data(host_resp_data),
    .io_pcr_en(pcr_en), .io_pcr_wen(pcr_wen), .io_pcr_addr(pcr_addr),
    .io_pcr_wdata(pcr_wdata), .io_pcr_rdata(pcr_rdata),
    .io_busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // PCR file model: read data appears in the cycle after the strobe and is held there.
  always @(negedge clk) begin
    if (pcr_en) begin
      en_log.push_back('{cyc, pcr_wen, pcr_addr, pcr_wdata});
      pcr_rdata = pcr_mem[pcr_addr];
      if (pcr_wen) pcr_mem[pcr_addr] = pcr_wdata;
      rd_hold = 1'b1;
    end else begin
      if (!rd_hold) pcr_rdata = {$urandom, $urandom};
      rd_hold = 1'b0;
    end
  end

  // ---------------- driver ----------------
  task automatic drive_req(input bit is_host, input logic rw, input logic [4:0] addr,
                           input logic [63:0] data, input int stall,
                           output int t_fire, output int t_resp,
                           output logic [63:0] rdata, output bit stable);
    acc_t a;
    t_fire = -1;
    t_resp = -1;
    rdata  = '0;
    stable = 1'b1;
    @(negedge clk);
    if (is_host) begin
      host_req_valid = 1'b1; host_req_rw = rw; host_req_addr = addr; host_req_data = data;
    end else begin
      core_req_valid = 1'b1; core_req_rw = rw; core_req_addr = addr; core_req_data = data;
    end
    for (int i = 0; i < 200 && t_fire < 0; i++) begin
      #1;
      if (is_host ? host_req_ready : core_req_ready) begin
        t_fire = cyc;
        if (is_host) host_exp_q.push_back(rw ? 64'h0 : ref_mem[addr]);
        else         core_exp_q.push_back(rw ? 64'h0 : ref_mem[addr]);
        a.cyc = cyc + 1; a.wen = rw; a.addr = addr; a.wdata = data;
        exp_acc_q.push_back(a);
        if (rw) ref_mem[addr] = data;
      end
      @(negedge clk);
    end
    if (is_host) begin
      host_req_valid = 1'b0; host_req_addr = 5'($urandom); host_req_data = {$urandom, $urandom};
    end else begin
      core_req_valid = 1'b0; core_req_addr = 5'($urandom); core_req_data = {$urandom, $urandom};
    end
    if (t_fire < 0) return;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (is_host ? host_resp_valid : core_resp_valid) begin
        t_resp = cyc;
        rdata  = is_host ? host_resp_data : core_resp_data;
        break;
      end
      @(negedge clk);
    end
    if (t_resp < 0) return;
    if (is_host) begin
      for (int s = 0; s < stall; s++) begin
        @(negedge clk); #1;
        if (!host_resp_valid || host_resp_data !== rdata) stable = 1'b0;
      end
      host_resp_ready = 1'b1;
      @(negedge clk);
      host_resp_ready = 1'b0;
      #1;
      if (host_resp_valid) stable = 1'b0;
    end else begin
      @(negedge clk); #1;
      if (core_resp_valid) stable = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    core_req_valid = 1'b1; host_req_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL reset_outs: got %0h expected 0", outs);
    end
    @(negedge clk);
    core_req_valid = 1'b0; host_req_valid = 1'b0;
    #2 reset_n = 1'b1;
    en_log.delete();
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL post_reset_outs: got %0h expected 0", outs);
    end
    total++;
    if (en_log.size() != 0) begin
      bad++; $display("FAIL post_reset_pcr_en: got %0d strobes expected 0", en_log.size());
    end
  endtask

  task automatic test_core_read();
    int tf, tr; logic [63:0] rd; bit st; acc_t g;
    pcr_mem[3] = 64'hAB; ref_mem[3] = 64'hAB;
    en_log.delete(); exp_acc_q.delete();
    drive_req(1'b0, 1'b0, 5'h03, 64'h0, 0, tf, tr, rd, st);
    g = '{-1, 1'bx, 5'bx, 64'bx};
    if (en_log.size() > 0) g = en_log.pop_front();
    total++;
    if (g.cyc !== tf + 1 || tf < 0) begin
      bad++; $display("FAIL t1_en_cycle: got %0d expected %0d", g.cyc, tf + 1);
    end
    total++;
    if ({g.wen, g.addr} !== {1'b0, 5'h03}) begin
      bad++; $display("FAIL t1_en_fields: got wen=%0b addr=%0h expected wen=0 addr=3", g.wen, g.addr);
    end
    total++;
    if (tr !== tf + 3) begin
      bad++; $display("FAIL t1_latency: got %0d expected %0d", tr - tf, 3);
    end
    total++;
    if (rd !== 64'hAB) begin
      bad++; $display("FAIL t1_rdata: got %0h expected ab", rd);
    end
    total++;
    if (!st) begin
      bad++; $display("FAIL t1_pulse: got resp_valid longer than 1 cycle expected 1 cycle");
    end
    if (core_exp_q.size() > 0) void'(core_exp_q.pop_front());
  endtask

  task automatic test_host_write();
    int tf, tr; logic [63:0] rd, e; bit st; acc_t g;
    en_log.delete(); exp_acc_q.delete();
    drive_req(1'b1, 1'b1, 5'h1F, 64'hDEAD_BEEF, 5, tf, tr, rd, st);
    g = '{-1, 1'bx, 5'bx, 64'bx};
    if (en_log.size() > 0) g = en_log.pop_front();
    total++;
    if (g.cyc !== tf + 1 || {g.wen, g.addr, g.wdata} !== {1'b1, 5'h1F, 64'hDEAD_BEEF}) begin
      bad++;
      $display("FAIL t2_en: got cyc=%0d wen=%0b addr=%0h wdata=%0h expected cyc=%0d wen=1 addr=1f wdata=deadbeef",
               g.cyc, g.wen, g.addr, g.wdata, tf + 1);
    end
    total++;
    if (tr !== tf + 3 || rd !== 64'h0) begin
      bad++; $display("FAIL t2_resp: got lat=%0d data=%0h expected lat=3 data=0", tr - tf, rd);
    end
    total++;
    if (!st) begin
      bad++; $display("FAIL t2_hold: got unstable host response expected held until ready");
    end
    if (host_exp_q.size() > 0) void'(host_exp_q.pop_front());
    drive_req(1'b0, 1'b0, 5'h1F, 64'h0, 0, tf, tr, rd, st);
    e = core_exp_q.size() > 0 ? core_exp_q.pop_front() : 64'hx;
    total++;
    if (rd !== e || rd !== 64'hDEAD_BEEF) begin
      bad++; $display("FAIL t2_readback: got %0h expected %0h", rd, e);
    end
  endtask

  task automatic test_contention();
    int tfc, trc, tfh, trh; logic [63:0] rdc, rdh, ec, eh; bit stc, sth;
    fork
      drive_req(1'b0, 1'b0, 5'($urandom), 64'h0, 0, tfc, trc, rdc, stc);
      drive_req(1'b1, 1'b0, 5'($urandom), 64'h0, 0, tfh, trh, rdh, sth);
    join
    total++;
    if (tfc < 0 || tfh !== trc + 1) begin
      bad++; $display("FAIL t3_order: got host_fire=%0d expected %0d (core resp %0d)", tfh, trc + 1, trc);
    end
    ec = core_exp_q.size() > 0 ? core_exp_q.pop_front() : 64'hx;
    eh = host_exp_q.size() > 0 ? host_exp_q.pop_front() : 64'hx;
    total++;
    if (rdc !== ec || rdh !== eh) begin
      bad++; $display("FAIL t3_data: got core=%0h host=%0h expected core=%0h host=%0h", rdc, rdh, ec, eh);
    end
    en_log.delete(); exp_acc_q.delete();
  endtask

  task automatic test_host_stall_blocks_core();
    int tfc, trc, tfh, trh; logic [63:0] rdc, rdh, ec, eh; bit stc, sth;
    fork
      drive_req(1'b1, 1'b1, 5'($urandom), {$urandom, $urandom}, 6, tfh, trh, rdh, sth);
      begin
        repeat (4) @(negedge clk);
        drive_req(1'b0, 1'b0, 5'($urandom), 64'h0, 0, tfc, trc, rdc, stc);
      end
    join
    total++;
    if (trh < 0 || tfc !== trh + 6 + 1) begin
      bad++; $display("FAIL t4_core_blocked: got core_fire=%0d expected %0d", tfc, trh + 7);
    end
    total++;
    if (!sth || rdh !== 64'h0) begin
      bad++; $display("FAIL t4_host_hold: got stable=%0b data=%0h expected stable=1 data=0", sth, rdh);
    end
    ec = core_exp_q.size() > 0 ? core_exp_q.pop_front() : 64'hx;
    eh = host_exp_q.size() > 0 ? host_exp_q.pop_front() : 64'hx;
    total++;
    if (rdc !== ec) begin
      bad++; $display("FAIL t4_core_data: got %0h expected %0h", rdc, ec);
    end
    en_log.delete(); exp_acc_q.delete();
  endtask

  task automatic test_random();
    int tf, tr; logic [63:0] rd, e; bit st, h; acc_t x, g;
    en_log.delete(); exp_acc_q.delete();
    for (int n = 0; n < 24; n++) begin
      h = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drive_req(h, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                h ? $urandom_range(0, 3) : 0, tf, tr, rd, st);
      if (h) e = host_exp_q.size() > 0 ? host_exp_q.pop_front() : 64'hx;
      else   e = core_exp_q.size() > 0 ? core_exp_q.pop_front() : 64'hx;
      total++;
      if (tf < 0 || tr !== tf + 3 || rd !== e || !st) begin
        bad++;
        $display("FAIL rand_resp[%0d]: got host=%0b lat=%0d data=%0h stable=%0b expected lat=3 data=%0h stable=1",
                 n, h, tr - tf, rd, st, e);
      end
    end
    while (exp_acc_q.size() > 0) begin
      x = exp_acc_q.pop_front();
      g = '{-1, 1'bx, 5'bx, 64'bx};
      if (en_log.size() > 0) g = en_log.pop_front();
      total++;
      if ({g.cyc, g.wen, g.addr, g.wen ? g.wdata : 64'h0} !==
          {x.cyc, x.wen, x.addr, x.wen ? x.wdata : 64'h0}) begin
        bad++;
        $display("FAIL rand_pcr: got cyc=%0d wen=%0b addr=%0h wdata=%0h expected cyc=%0d wen=%0b addr=%0h wdata=%0h",
                 g.cyc, g.wen, g.addr, g.wdata, x.cyc, x.wen, x.addr, x.wdata);
      end
    end
    total++;
    if (en_log.size() != 0) begin
      bad++; $display("FAIL rand_extra_pcr: got %0d extra strobes expected 0", en_log.size());
    end
  endtask

  task automatic test_reset_mid_access();
    int events;
    @(negedge clk);
    core_req_valid = 1'b1; core_req_rw = 1'b0; core_req_addr = 5'($urandom);
    #1;
    total++;
    if (core_req_ready !== 1'b1) begin
      bad++; $display("FAIL t5_grant: got ready=%0b expected 1", core_req_ready);
    end
    @(negedge clk);
    core_req_valid = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    total++;
    if (outs !== '0) begin
      bad++; $display("FAIL t5_async_reset: got %0h expected 0", outs);
    end
    @(negedge clk);
    reset_n = 1'b1;
    en_log.delete();
    events = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (core_resp_valid || host_resp_valid || pcr_en) events++;
    end
    total++;
    if (events != 0 || en_log.size() != 0) begin
      bad++; $display("FAIL t5_no_activity: got %0d events expected 0", events);
    end
  endtask

  task automatic test_starvation();
    int losses = 0;
    bit host_fired = 1'b0;
    core_req_rw = 1'b0; core_req_addr = 5'h0;
    host_req_rw = 1'b0; host_req_addr = 5'h1;
    host_resp_ready = 1'b1;
    @(negedge clk);
    core_req_valid = 1'b1; host_req_valid = 1'b1;
    for (int w = 0; w < 60 && !host_fired; w++) begin
      #1;
      if (host_req_ready) host_fired = 1'b1;
      else if (core_req_ready) losses++;
      @(negedge clk);
    end
    core_req_valid = 1'b0; host_req_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (!busy) break;
      @(negedge clk);
    end
    host_resp_ready = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL t6_drain: got busy=%0b expected 0", busy);
    end
`ifdef PCR_ARB_STARVE_EN
    total++;
    if (!host_fired || losses != STARVE_LIMIT) begin
      bad++; $display("FAIL t6_starve: got granted=%0b losses=%0d expected granted=1 losses=%0d",
                      host_fired, losses, STARVE_LIMIT);
    end
`else
    total++;
    if (host_fired || losses < 10) begin
      bad++; $display("FAIL t6_fixed_prio: got granted=%0b losses=%0d expected granted=0 losses>=10",
                      host_fired, losses);
    end
`endif
    en_log.delete(); exp_acc_q.delete();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    logic [63:0] v;
    for (int i = 0; i < 32; i++) begin
      v = {$urandom, $urandom};
      pcr_mem[i] = v;
      ref_mem[i] = v;
    end
    reset_n = 1'b0;
    core_req_valid = 1'b0; core_req_rw = 1'b0; core_req_addr = '0; core_req_data = '0;
    host_req_valid = 1'b0; host_req_rw = 1'b0; host_req_addr = '0; host_req_data = '0;
    host_resp_ready = 1'b0;
    test_reset();
    test_core_read();
    test_host_write();
    test_contention();
    test_host_stall_blocks_core();
    test_random();
    test_reset_mid_access();
    test_starvation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
